ofmap_writeback: RTL and testbench
==================================

Name: ofmap_writeback

Overview:
- Output stage directly downstream of `top`. Consumes the `o_ofmap`/`o_ofmap_valid` stream and the `o_done` flag.
- Requantizes each 2×DATA_WIDTH accumulator result to DATA_WIDTH (optional ReLU, arithmetic shift, saturation).
- Packs results little-endian into SRAM_DATA_WIDTH words and writes them to the output scratchpad.
- A 2-entry word FIFO absorbs write-port backpressure.

Parameters:
- DATA_WIDTH, 8, element width after requantization; the input is 2*DATA_WIDTH.
- SRAM_DATA_WIDTH, 64, output word width. LANES = SRAM_DATA_WIDTH/DATA_WIDTH, which must be an integer ≥ 2.
- ADDR_WIDTH, 8, output scratchpad address width.

Ports:
- i_clk  in  1  sole clock; all state updates on the rising edge.
- i_nrst  in  1  asynchronous active-low reset.
- i_reg_clear  in  1  synchronous clear: returns to RUN, lane=0, FIFO emptied, addr=i_base_addr, counters and flags cleared.
- i_ofmap  in  2*DATA_WIDTH  signed accumulator result.
- i_ofmap_valid  in  1  i_ofmap valid this cycle; there is no backpressure upstream.
- i_done  in  1  upstream finished; level or pulse, sampled only in RUN.
- i_relu_en  in  1  clamp negative values to 0 before shifting.
- i_shift  in  4  arithmetic right-shift amount, 0..15.
- i_base_addr  in  ADDR_WIDTH  first write address; loaded at reset and at i_reg_clear.
- o_wr_data  out  SRAM_DATA_WIDTH  FIFO head word.
- o_wr_addr  out  ADDR_WIDTH  address for o_wr_data.
- o_wr_en  out  1  FIFO non-empty.
- i_wr_ready  in  1  write accepted when o_wr_en && i_wr_ready.
- o_word_count  out  ADDR_WIDTH+1  words written since clear.
- o_overflow  out  1  sticky error flag.
- o_done  out  1  all data written; held until i_reg_clear.

Behaviour:
- Reset (async, i_nrst=0) and i_reg_clear produce the same state:
  - state=RUN, lane=0, FIFO empty, pack register=0.
  - o_wr_en=0, o_wr_data=0, o_wr_addr=i_base_addr.
  - o_word_count=0, o_overflow=0, o_done=0.
  - i_reg_clear has priority over every other event in the same cycle.
- Requantization, combinational on i_ofmap (x, signed 2*DATA_WIDTH):
  - If i_relu_en and x<0, then x=0.
  - y = x >>> i_shift.
  - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; q = low DATA_WIDTH bits of y.
- Packing:
  - An accepted element writes q into lane `lane` (bits [lane*DATA_WIDTH +: DATA_WIDTH]), then lane increments.
  - When lane==LANES-1, the completed word (including this element) is pushed to the FIFO at the same edge, and lane returns to 0.
  - First possible o_wr_en: one cycle after the completing element, if the FIFO was empty.
- FIFO:
  - Depth 2, push and pop in the same cycle allowed, including when full.
  - Each pop increments o_wr_addr (wraps modulo 2^ADDR_WIDTH) and o_word_count.
  - Push while full with no pop: the word is dropped, o_overflow=1, and lane still resets to 0.
- States:
  - RUN: elements are accepted.
    - On i_done, the element valid in the same cycle is accepted first, then the state moves to FLUSH if lane (after update) >0, else to DRAIN.
    - A word completed in the same cycle as i_done is pushed normally.
  - FLUSH: the partial word is pushed with unused upper lanes zero. The push happens in the first cycle the FIFO is not full or a pop occurs. Then lane=0 and the state moves to DRAIN.
  - DRAIN: when the FIFO is empty, move to DONE.
  - DONE: o_done=1 (registered, asserted the cycle after entry) and held until i_reg_clear.
  - i_ofmap_valid in FLUSH, DRAIN or DONE: the element is ignored and o_overflow=1.
- Mid-operation reset or clear discards all buffered data; no write is issued afterwards.

Test Plan:
- LANES=8, i_shift=2, i_relu_en=1, inputs 0x0010, 0xFFF0, 0x1000, 0x0007, then 4×0x0004, i_wr_ready=1:
  - One write at i_base_addr=0x10 with data 0x01010101_01_7F_00_04.
  - o_word_count=1.
- i_relu_en=0, i_shift=0, inputs 0xFFF0 and 0x8000:
  - Lanes 0x F0 and 0x80.
  - Same data with i_shift=2: lanes 0xFC and 0x80 (-8192 saturates).
- 24 back-to-back valids with i_wr_ready=0 for 20 cycles:
  - Words 1–2 are buffered and word 3 is dropped; o_overflow=1.
  - After i_wr_ready=1: exactly 2 writes at addresses base and base+1.
- 11 elements, then an i_done pulse:
  - Second write has lanes 0–2 = data and lanes 3–7 = 0.
  - o_done rises after that write and holds.
  - Further valids set o_overflow.
- i_base_addr=0xFF, 2 full words:
  - Addresses 0xFF then 0x00; o_word_count=2.
- i_nrst pulsed low mid-word (lane=5) and mid-stall (FIFO=2):
  - All outputs return to their reset values immediately.
  - No write follows; the next 8 elements form a word at i_base_addr.

Source files
------------

// File: rtl/ofmap_writeback.sv
// Output writeback stage: requantizes accumulator results, packs them into
// scratchpad words and writes them out through a 2-entry word FIFO.
// LANES = SRAM_DATA_WIDTH / DATA_WIDTH must be an integer >= 2.
module ofmap_writeback #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SRAM_DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH      = 8
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_reg_clear,
  input  logic [2*DATA_WIDTH-1:0]      i_ofmap,
  input  logic                         i_ofmap_valid,
  input  logic                         i_done,
  input  logic                         i_relu_en,
  input  logic [3:0]                   i_shift,
  input  logic [ADDR_WIDTH-1:0]        i_base_addr,
  output logic [SRAM_DATA_WIDTH-1:0]   o_wr_data,
  output logic [ADDR_WIDTH-1:0]        o_wr_addr,
  output logic                         o_wr_en,
  input  logic                         i_wr_ready,
  output logic [ADDR_WIDTH:0]          o_word_count,
  output logic                         o_overflow,
  output logic                         o_done
);

  localparam int unsigned ACC_W  = 2 * DATA_WIDTH;
  localparam int unsigned LANES  = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned LANE_W = $clog2(LANES);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, DONE} state_t;

  state_t                      state;
  logic [LANE_W-1:0]           lane;
  logic [SRAM_DATA_WIDTH-1:0]  pack;
  logic [SRAM_DATA_WIDTH-1:0]  mem [2];
  logic                        rd_ptr;
  logic [1:0]                  fifo_count;
  logic [ADDR_WIDTH-1:0]       addr_off;

  logic signed [ACC_W-1:0]     relu_c;
  logic signed [ACC_W-1:0]     shifted_c;
  logic [DATA_WIDTH-1:0]       q_c;
  logic [SRAM_DATA_WIDTH-1:0]  word_c;
  logic [SRAM_DATA_WIDTH-1:0]  push_data_c;
  logic [LANE_W-1:0]           lane_next_c;
  logic                        accept_c;
  logic                        last_c;
  logic                        full_c;
  logic                        pop_c;
  logic                        push_c;
  logic                        push_ok_c;
  logic                        drop_c;
  logic                        wr_ptr_c;

  // Requantize: optional ReLU, arithmetic shift, saturate to DATA_WIDTH
  always_comb begin
    relu_c = $signed(i_ofmap);
    if (i_relu_en && relu_c[ACC_W-1]) relu_c = '0;
    shifted_c = relu_c >>> i_shift;
    if (shifted_c > Q_MAX)      q_c = Q_MAX[DATA_WIDTH-1:0];
    else if (shifted_c < Q_MIN) q_c = Q_MIN[DATA_WIDTH-1:0];
    else                        q_c = shifted_c[DATA_WIDTH-1:0];
  end

  // Pack word including the current element, and push/pop handshake
  always_comb begin
    word_c = pack;
    word_c[lane*DATA_WIDTH +: DATA_WIDTH] = q_c;
    accept_c = (state == RUN) && i_ofmap_valid;
    last_c   = (lane == LANE_W'(LANES - 1));
    full_c   = (fifo_count == 2'd2);
    pop_c    = (fifo_count != 2'd0) && i_wr_ready;
    // FLUSH pushes the partial word only once it fits, so it never drops
    push_c   = (accept_c && last_c) || ((state == FLUSH) && (!full_c || pop_c));
    push_ok_c = push_c && (!full_c || pop_c);
    drop_c    = push_c && !push_ok_c;
    push_data_c = (state == FLUSH) ? pack : word_c;
    // Next free slot; when full this is the slot being popped this cycle
    wr_ptr_c = rd_ptr ^ fifo_count[0];
    lane_next_c = lane;
    if (accept_c) lane_next_c = last_c ? '0 : lane + LANE_W'(1);
  end

  assign o_wr_en   = (fifo_count != 2'd0);
  assign o_wr_data = o_wr_en ? mem[rd_ptr] : '0;
  // Address is tracked as an offset so reset/clear need no async data load;
  // i_base_addr is expected to be stable between clears.
  assign o_wr_addr = i_base_addr + addr_off;

  // Control FSM, packing register, FIFO and status flags
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= RUN;
      lane         <= '0;
      pack         <= '0;
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      addr_off     <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
      o_done       <= 1'b0;
    end else if (i_reg_clear) begin
      state        <= RUN;
      lane         <= '0;
      pack         <= '0;
      mem[0]       <= '0;
      mem[1]       <= '0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      addr_off     <= '0;
      o_word_count <= '0;
      o_overflow   <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr       <= ~rd_ptr;
        addr_off     <= addr_off + ADDR_WIDTH'(1);
        o_word_count <= o_word_count + (ADDR_WIDTH + 1)'(1);
      end
      if (push_ok_c) mem[wr_ptr_c] <= push_data_c;
      case ({push_ok_c, pop_c})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop_c || (i_ofmap_valid && (state != RUN))) o_overflow <= 1'b1;
      o_done <= (state == DONE);

      case (state)
        RUN: begin
          if (accept_c) begin
            lane <= lane_next_c;
            pack <= last_c ? '0 : word_c;
          end
          if (i_done) state <= (lane_next_c != '0) ? FLUSH : DRAIN;
        end
        FLUSH: begin
          if (push_ok_c) begin
            lane  <= '0;
            pack  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_count == 2'd0) state <= DONE;
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Scoreboard bench for ofmap_writeback: expected writes are queued as
// elements are driven and compared as the DUT issues them.
module tb_ofmap_writeback;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 64;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  logic            i_clk = 1'b0;
  logic            i_nrst;
  logic            i_reg_clear;
  logic [2*DW-1:0] i_ofmap;
  logic            i_ofmap_valid;
  logic            i_done;
  logic            i_relu_en;
  logic [3:0]      i_shift;
  logic [AW-1:0]   i_base_addr;
  logic [SW-1:0]   o_wr_data;
  logic [AW-1:0]   o_wr_addr;
  logic            o_wr_en;
  logic            i_wr_ready;
  logic [AW:0]     o_word_count;
  logic            o_overflow;
  logic            o_done;

  int checks = 0;
  int errors = 0;

  wr_t           exp_q [$];
  wr_t           e;
  logic [SW-1:0] acc;
  int            lane_m;
  logic [AW-1:0] addr_m;

  ofmap_writeback #(.DATA_WIDTH(DW), .SRAM_DATA_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear),
    .i_ofmap(i_ofmap), .i_ofmap_valid(i_ofmap_valid), .i_done(i_done),
    .i_relu_en(i_relu_en), .i_shift(i_shift), .i_base_addr(i_base_addr),
    .o_wr_data(o_wr_data), .o_wr_addr(o_wr_addr), .o_wr_en(o_wr_en),
    .i_wr_ready(i_wr_ready), .o_word_count(o_word_count),
    .o_overflow(o_overflow), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference requantizer
  function automatic logic [DW-1:0] rq(input logic [2*DW-1:0] x, input logic relu, input logic [3:0] sh);
    logic signed [2*DW-1:0] v;
    v = x;
    if (relu && v < 0) v = '0;
    v = v >>> sh;
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[DW-1:0];
  endfunction

  task automatic model_reset(input logic [AW-1:0] base);
    acc = '0;
    lane_m = 0;
    addr_m = base;
    exp_q.delete();
  endtask

  // Drive one element for one cycle; keep=1 queues the completed word
  task automatic send(input logic [2*DW-1:0] v, input bit keep);
    acc[lane_m*DW +: DW] = rq(v, i_relu_en, i_shift);
    i_ofmap = v;
    i_ofmap_valid = 1'b1;
    @(posedge i_clk); #1;
    i_ofmap_valid = 1'b0;
    lane_m++;
    if (lane_m == SW / DW) begin
      if (keep) begin
        exp_q.push_back('{addr: addr_m, data: acc});
        addr_m++;
      end
      acc = '0;
      lane_m = 0;
    end
  endtask

  task automatic push_exp(input logic [SW-1:0] d);
    exp_q.push_back('{addr: addr_m, data: d});
    addr_m++;
  endtask

  task automatic do_clear();
    i_reg_clear = 1'b1;
    @(posedge i_clk); #1;
    i_reg_clear = 1'b0;
    model_reset(i_base_addr);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || o_wr_en) && k < 200) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Write monitor: every accepted write must match the scoreboard head
  always @(negedge i_clk) begin
    if (i_nrst && !i_reg_clear && o_wr_en && i_wr_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {56'd0, o_wr_addr}, 64'hdead);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(o_wr_addr), 64'(e.addr));
        check("wr_data", o_wr_data, e.data);
      end
      check("done_during_write", 64'(o_done), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    i_nrst = 1'b0;
    i_reg_clear = 1'b0;
    i_ofmap = '0;
    i_ofmap_valid = 1'b0;
    i_done = 1'b0;
    i_relu_en = 1'b1;
    i_shift = 4'd2;
    i_base_addr = 8'h10;
    i_wr_ready = 1'b1;
    model_reset(8'h10);
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_wr_en", 64'(o_wr_en), 64'd0);
    check("rst_wr_data", o_wr_data, 64'd0);
    check("rst_wr_addr", 64'(o_wr_addr), 64'h10);
    check("rst_word_count", 64'(o_word_count), 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    i_nrst = 1'b1;
    cycles(2);

    // Basic packing with ReLU and shift
    send(16'h0010, 0); send(16'hfff0, 0); send(16'h1000, 0); send(16'h0007, 0);
    send(16'h0004, 0); send(16'h0004, 0); send(16'h0004, 0); send(16'h0004, 0);
    push_exp(64'h01010101_017f0004);
    check("first_wr_en_latency", 64'(o_wr_en), 64'd1);
    wait_drain();
    check("t1_word_count", 64'(o_word_count), 64'd1);

    // Signed values without ReLU, with and without shift saturation
    i_relu_en = 1'b0;
    i_shift = 4'd0;
    send(16'hfff0, 0); send(16'h8000, 0);
    for (int i = 0; i < 6; i++) send(16'h0000, 0);
    push_exp(64'h0000_0000_0000_80f0);
    i_shift = 4'd2;
    send(16'hfff0, 0); send(16'h8000, 0);
    for (int i = 0; i < 6; i++) send(16'h0000, 0);
    push_exp(64'h0000_0000_0000_80fc);
    wait_drain();
    check("t2_word_count", 64'(o_word_count), 64'd3);
    check("t2_overflow", 64'(o_overflow), 64'd0);

    // Backpressure: two words buffered, third dropped
    do_clear();
    check("clear_word_count", 64'(o_word_count), 64'd0);
    i_relu_en = 1'b1;
    i_shift = 4'd3;
    i_wr_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(16'($urandom_range(0, 65535)), i < 16);
    check("t3_overflow", 64'(o_overflow), 64'd1);
    check("t3_stalled_wr_en", 64'(o_wr_en), 64'd1);
    check("t3_stalled_count", 64'(o_word_count), 64'd0);
    i_wr_ready = 1'b1;
    wait_drain();
    cycles(5);
    check("t3_word_count", 64'(o_word_count), 64'd2);
    check("t3_overflow_sticky", 64'(o_overflow), 64'd1);

    // Partial flush on i_done, then DONE and late valids
    do_clear();
    i_shift = 4'd1;
    for (int i = 0; i < 11; i++) send(16'($urandom_range(0, 4000)), 1);
    push_exp(acc);
    acc = '0;
    lane_m = 0;
    i_done = 1'b1;
    @(posedge i_clk); #1;
    i_done = 1'b0;
    wait_drain();
    for (int k = 0; k < 20 && !o_done; k++) begin @(posedge i_clk); #1; end
    check("t4_done", 64'(o_done), 64'd1);
    check("t4_word_count", 64'(o_word_count), 64'd2);
    check("t4_overflow_clean", 64'(o_overflow), 64'd0);
    i_ofmap = 16'h0100;
    i_ofmap_valid = 1'b1;
    @(posedge i_clk); #1;
    i_ofmap_valid = 1'b0;
    cycles(4);
    check("t4_late_valid_overflow", 64'(o_overflow), 64'd1);
    check("t4_done_held", 64'(o_done), 64'd1);
    check("t4_no_write", 64'(o_wr_en), 64'd0);

    // Address wrap
    i_base_addr = 8'hff;
    do_clear();
    check("t5_clear_done", 64'(o_done), 64'd0);
    check("t5_clear_addr", 64'(o_wr_addr), 64'hff);
    for (int i = 0; i < 16; i++) send(16'($urandom_range(0, 65535)), 1);
    wait_drain();
    check("t5_word_count", 64'(o_word_count), 64'd2);

    // Async reset mid-word
    i_base_addr = 8'h20;
    for (int i = 0; i < 5; i++) send(16'h0123, 0);
    i_nrst = 1'b0;
    #1;
    check("t6a_wr_en", 64'(o_wr_en), 64'd0);
    check("t6a_wr_addr", 64'(o_wr_addr), 64'h20);
    check("t6a_word_count", 64'(o_word_count), 64'd0);
    model_reset(8'h20);
    @(posedge i_clk); #1;
    i_nrst = 1'b1;

    // Async reset mid-stall with a full FIFO
    i_wr_ready = 1'b0;
    for (int i = 0; i < 24; i++) send(16'h0777, 0);
    check("t6b_pre_overflow", 64'(o_overflow), 64'd1);
    check("t6b_pre_wr_en", 64'(o_wr_en), 64'd1);
    i_nrst = 1'b0;
    #1;
    check("t6b_wr_en", 64'(o_wr_en), 64'd0);
    check("t6b_wr_data", o_wr_data, 64'd0);
    check("t6b_overflow", 64'(o_overflow), 64'd0);
    check("t6b_done", 64'(o_done), 64'd0);
    model_reset(8'h20);
    @(posedge i_clk); #1;
    i_nrst = 1'b1;
    i_wr_ready = 1'b1;
    cycles(5);
    check("t6b_no_write", 64'(o_word_count), 64'd0);
    for (int i = 0; i < 8; i++) send(16'($urandom_range(0, 65535)), 1);
    wait_drain();
    check("t6_word_count", 64'(o_word_count), 64'd1);

    cycles(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
